// File: rtl/fetch_queue.sv
// Instruction fetch queue between the fetch sequencer and decode.
// Circular buffer of {vaddr, fid, insn, bp_taken} entries with wrap-bit
// pointers. readyn warns the sequencer early enough to absorb its in-flight
// fetches, and a branch commit override empties the queue in one cycle.
//
// Handshake: an entry is accepted when i_valid is high, the registered
// occupancy is below DEPTH and no flush is requested. The head is consumed
// on any cycle with o_valid && o_ready and no flush. A push into a full
// queue is dropped, even if a pop happens in the same cycle, and sets the
// sticky o_overflow flag.
module fetch_queue #(
   parameter int DEPTH        = 8,
   parameter int AFULL_MARGIN = 2
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     bco_valid,
   input  logic                     i_valid,
   input  logic [31:0]              i_vaddr,
   input  logic [7:0]               i_fid,
   input  logic [31:0]              i_insn,
   input  logic                     i_bp_taken,
   output logic                     readyn,
   output logic                     o_valid,
   output logic [31:0]              o_vaddr,
   output logic [7:0]               o_fid,
   output logic [31:0]              o_insn,
   output logic                     o_bp_taken,
   input  logic                     o_ready,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 32 + 8 + 32 + 1;
   localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
   localparam logic [AW:0] MARGIN_C = (AW+1)'(AFULL_MARGIN);

   logic [EW-1:0] mem [DEPTH];
   logic [AW:0]   wptr;
   logic [AW:0]   rptr;
   logic [AW:0]   count;
   logic          full;
   logic          push;
   logic          pop;
   logic          drop;

   // Occupancy comes only from the registered pointers, so full, readyn
   // and o_valid never depend on this cycle's inputs.
   assign count = wptr - rptr;
   assign full  = (count == DEPTH_C);

   // A same-cycle pop does not make room for a push: full is judged on
   // the registered count.
   assign push = i_valid && !full && !bco_valid;
   assign pop  = o_valid && o_ready && !bco_valid;
   assign drop = i_valid && full && !bco_valid;

   assign o_valid = (count != '0);
   assign o_count = count;
   assign readyn  = ((DEPTH_C - count) <= MARGIN_C);

   // Head is a combinational read at rptr; a written entry becomes visible
   // the cycle after the write (no bypass).
   assign {o_vaddr, o_fid, o_insn, o_bp_taken} = mem[rptr[AW-1:0]];

   // Entry storage: written on push, never cleared (flush/reset only move pointers).
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr[AW-1:0]] <= {i_vaddr, i_fid, i_insn, i_bp_taken};
      end
   end

   // Pointer update: reset and flush both rewind to an empty queue at index 0.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wptr <= '0;
         rptr <= '0;
      end else if (bco_valid) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   // Sticky overflow: set when an entry is dropped on a full queue, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         o_overflow <= 1'b0;
      end else if (drop) begin
         o_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: cycle-stepped driver with a queue
// model; expected entries are queued on push and compared against the head
// on every pop. Inputs are driven and outputs sampled on the falling edge.
module tb_fetch_queue;

   localparam int DEPTH  = 8;
   localparam int MARGIN = 2;
   localparam int EW     = 73;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn;
   logic        bco_valid;
   logic        i_valid;
   logic [31:0] i_vaddr;
   logic [7:0]  i_fid;
   logic [31:0] i_insn;
   logic        i_bp_taken;
   logic        readyn;
   logic        o_valid;
   logic [31:0] o_vaddr;
   logic [7:0]  o_fid;
   logic [31:0] o_insn;
   logic        o_bp_taken;
   logic        o_ready;
   logic [3:0]  o_count;
   logic        o_overflow;

   fetch_queue #(.DEPTH(DEPTH), .AFULL_MARGIN(MARGIN)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .bco_valid  (bco_valid),
      .i_valid    (i_valid),
      .i_vaddr    (i_vaddr),
      .i_fid      (i_fid),
      .i_insn     (i_insn),
      .i_bp_taken (i_bp_taken),
      .readyn     (readyn),
      .o_valid    (o_valid),
      .o_vaddr    (o_vaddr),
      .o_fid      (o_fid),
      .o_insn     (o_insn),
      .o_bp_taken (o_bp_taken),
      .o_ready    (o_ready),
      .o_count    (o_count),
      .o_overflow (o_overflow)
   );

   // ---------------- scoreboard state ----------------
   logic [EW-1:0] exp_q[$];
   logic          m_ovf;
   int            checks = 0;
   int            errors = 0;

   task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Compare every observable output against the model for this cycle.
   task automatic check_state(input string tag);
      check({tag, "_valid"},    EW'(o_valid),    EW'(exp_q.size() != 0));
      check({tag, "_count"},    EW'(o_count),    EW'(exp_q.size()));
      check({tag, "_readyn"},   EW'(readyn),     EW'((DEPTH - exp_q.size()) <= MARGIN));
      check({tag, "_overflow"}, EW'(o_overflow), EW'(m_ovf));
   endtask

   // ---------------- driver ----------------
   // One clock cycle: drive inputs, check outputs, advance the model, step the clock.
   task automatic cycle(input logic v, input logic [31:0] va, input logic [7:0] fid,
                        input logic [31:0] insn, input logic bp, input logic rdy,
                        input logic bco);
      logic pop;
      logic full;
      i_valid    = v;
      i_vaddr    = va;
      i_fid      = fid;
      i_insn     = insn;
      i_bp_taken = bp;
      o_ready    = rdy;
      bco_valid  = bco;
      check_state("cyc");
      pop  = (exp_q.size() != 0) && rdy && !bco;
      full = (exp_q.size() == DEPTH);
      if (pop) check("head", {o_vaddr, o_fid, o_insn, o_bp_taken}, exp_q[0]);
      if (bco) begin
         exp_q.delete();
      end else begin
         if (pop) void'(exp_q.pop_front());
         if (v) begin
            if (full) m_ovf = 1'b1;
            else exp_q.push_back({va, fid, insn, bp});
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push_entry(input logic [31:0] va, input logic [7:0] fid, input logic rdy);
      cycle(1'b1, va, fid, ~va, fid[0], rdy, 1'b0);
   endtask

   task automatic idle(input logic rdy);
      cycle(1'b0, 32'h0, 8'h0, 32'h0, 1'b0, rdy, 1'b0);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      i_valid = 1'b0; bco_valid = 1'b0; o_ready = 1'b0;
      i_vaddr = '0; i_fid = '0; i_insn = '0; i_bp_taken = 1'b0;
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      exp_q.delete();
      m_ovf = 1'b0;
      check("rst_valid",    EW'(o_valid),    EW'(1'b0));
      check("rst_count",    EW'(o_count),    EW'(0));
      check("rst_readyn",   EW'(readyn),     EW'(1'b0));
      check("rst_overflow", EW'(o_overflow), EW'(1'b0));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      resetn = 1'b1;
      m_ovf  = 1'b0;
      @(negedge clk);
      do_reset();

      // 1: four pushes, decode stalled
      for (int i = 0; i < 4; i++) push_entry(32'h8000_0000 + 32'(4*i), 8'(i), 1'b0);
      check("t1_count",  EW'(o_count), EW'(4));
      check("t1_valid",  EW'(o_valid), EW'(1'b1));
      check("t1_vaddr",  EW'(o_vaddr), EW'(32'h8000_0000));
      check("t1_readyn", EW'(readyn),  EW'(1'b0));

      // 2: fill from empty, readyn at count 6, then full and overflow
      do_reset();
      for (int i = 0; i < 5; i++) push_entry(32'h1000 + 32'(4*i), 8'(i), 1'b0);
      check("t2_readyn5", EW'(readyn), EW'(1'b0));
      push_entry(32'h1014, 8'd5, 1'b0);
      check("t2_readyn6", EW'(readyn), EW'(1'b1));
      push_entry(32'h1018, 8'd6, 1'b0);
      push_entry(32'h101C, 8'd7, 1'b0);
      check("t2_count8", EW'(o_count), EW'(8));
      check("t2_ovf0",   EW'(o_overflow), EW'(1'b0));
      push_entry(32'h1020, 8'd8, 1'b0);
      check("t2_count_drop", EW'(o_count), EW'(8));
      check("t2_ovf1",   EW'(o_overflow), EW'(1'b1));

      // 3: full queue, push and pop together -> pop only
      push_entry(32'h1024, 8'd9, 1'b1);
      check("t3_count7", EW'(o_count), EW'(7));
      check("t3_ovf",    EW'(o_overflow), EW'(1'b1));
      for (int i = 0; i < 7; i++) idle(1'b1);
      check("t3_empty",  EW'(o_valid), EW'(1'b0));

      // 4: steady stream, 20 entries, decode always ready
      do_reset();
      for (int i = 0; i < 20; i++) begin
         push_entry(32'h2000 + 32'(4*i), 8'(i), 1'b1);
         check("t4_fid", EW'(o_fid), EW'(i));
         check("t4_readyn", EW'(readyn), EW'(1'b0));
      end
      idle(1'b1);
      check("t4_drained", EW'(o_count), EW'(0));

      // 5: flush at count 5 with a simultaneous push
      for (int i = 0; i < 5; i++) push_entry(32'h3000 + 32'(4*i), 8'(i), 1'b0);
      cycle(1'b1, 32'hBFC0_0000, 8'h55, 32'h1234_5678, 1'b1, 1'b0, 1'b1);
      check("t5_count", EW'(o_count), EW'(0));
      check("t5_valid", EW'(o_valid), EW'(1'b0));
      push_entry(32'h4000_0000, 8'h66, 1'b0);
      check("t5_head_vaddr", EW'(o_vaddr), EW'(32'h4000_0000));
      check("t5_head_fid",   EW'(o_fid),   EW'(8'h66));
      idle(1'b1);

      // 6: reset mid-operation with three entries and overflow set
      for (int i = 0; i < 9; i++) push_entry(32'h5000 + 32'(4*i), 8'(i), 1'b0);
      for (int i = 0; i < 5; i++) idle(1'b1);
      check("t6_count3", EW'(o_count), EW'(3));
      do_reset();

      // Random traffic: random valid/ready, rare flushes, random payloads
      for (int i = 0; i < 400; i++) begin
         cycle(1'b1 & ($urandom_range(0, 3) != 0), $urandom, 8'($urandom_range(0, 255)),
               $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 40) == 0));
      end
      for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
      check_state("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
